// File: rtl/ln_pkg.sv
// Shared constants and scheduler state encoding for the layer-norm row path.
package ln_pkg;
  localparam int FP16_W   = 16;
  localparam int LN_LANES = 64;
  localparam int ROW_W    = FP16_W * LN_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/ln_row_scheduler_if.sv
// Requester, LN datapath and control signals of the LN row scheduler.
interface ln_row_scheduler_if
  import ln_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ROW_W        = ln_pkg::ROW_W,
  parameter int MAX_INFLIGHT = 4
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][ROW_W-1:0] req_row;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          ln_x_valid;
  logic [ROW_W-1:0]              ln_a;
  logic                          ln_input_ready;
  logic                          ln_out_valid;
  logic [ROW_W-1:0]              ln_norm_vec;
  logic                          ln_downstream_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [ROW_W-1:0]              rsp_row;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic                          flush_req;
  logic                          flush_done;
  logic [CNT_W-1:0]              inflight_cnt;
  logic                          tag_err;

  modport master (
    output req_valid, req_row, ln_input_ready, ln_out_valid, ln_norm_vec,
           rsp_ready, flush_req,
    input  req_ready, ln_x_valid, ln_a, ln_downstream_ready, rsp_valid,
           rsp_row, flush_done, inflight_cnt, tag_err
  );

  modport slave (
    input  req_valid, req_row, ln_input_ready, ln_out_valid, ln_norm_vec,
           rsp_ready, flush_req,
    output req_ready, ln_x_valid, ln_a, ln_downstream_ready, rsp_valid,
           rsp_row, flush_done, inflight_cnt, tag_err
  );
endinterface

// File: rtl/ln_tag_fifo.sv
// In-order requester-ID FIFO; pointers carry an extra wrap bit for full/empty.
module ln_tag_fifo
  import ln_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ln_row_scheduler.sv
// Round-robin row scheduler sharing one LN datapath among NUM_REQ requesters,
// with credit-bounded issue, in-order return steering and flush/drain.
module ln_row_scheduler
  import ln_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ROW_W        = ln_pkg::ROW_W,
  parameter int MAX_INFLIGHT = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  ln_row_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  sched_state_t     state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, winner, head, idx;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] win_row;
  logic             any_valid, can_issue, issue, retire;
  logic             empty, full, tag_err_q, flush_done_c;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  assign win_row   = bus.req_row[winner];
  assign can_issue = (state != DRAIN) && (int'(cnt) < MAX_INFLIGHT) && !full;
  assign issue     = can_issue & any_valid & bus.ln_input_ready;
  assign retire    = bus.ln_out_valid & bus.ln_downstream_ready;

  ln_tag_fifo #(.W(ID_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (winner),
    .pop   (retire),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    bus.req_ready         = '0;
    bus.req_ready[winner] = can_issue & any_valid & bus.ln_input_ready;
    bus.rsp_valid         = '0;
    bus.rsp_valid[head]   = bus.ln_out_valid & ~empty;
  end

  assign bus.ln_x_valid          = can_issue & any_valid;
  assign bus.ln_a                = win_row;
  assign bus.ln_downstream_ready = ~empty & bus.rsp_ready[head];
  assign bus.rsp_row             = bus.ln_norm_vec;
  assign bus.flush_done          = flush_done_c;
  assign bus.inflight_cnt        = cnt;
  assign bus.tag_err             = tag_err_q;

  always_comb begin
    state_nxt    = state;
    flush_done_c = 1'b0;
    unique case (state)
      IDLE:  if (bus.flush_req) state_nxt = DRAIN;
             else if (any_valid) state_nxt = RUN;
      RUN:   if (bus.flush_req) state_nxt = DRAIN;
             else if (!any_valid && cnt == '0) state_nxt = IDLE;
      DRAIN: if (cnt == '0) begin
               state_nxt    = IDLE;
               flush_done_c = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue)
        rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      if (issue && !retire)      cnt <= cnt + 1'b1;
      else if (retire && !issue) cnt <= cnt - 1'b1;
      // A return with no recorded owner is unrecoverable until reset.
      if (bus.ln_out_valid && empty) tag_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ln_row_scheduler.sv
// Scoreboard bench for ln_row_scheduler: directed grant orders, stand-in LN model.
module tb_ln_row_scheduler;
  localparam int NR  = 4;
  localparam int RW  = 1024;
  localparam int MI  = 4;
  localparam int LAT = 8;

  typedef struct { logic [RW-1:0] row; int t; } ln_ent_t;
  typedef struct { int id; logic [RW-1:0] row; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_out = 1'b0;
  int   checks = 0, errors = 0;
  int   n_iss = 0, n_ret = 0, cyc = 0;
  int   sent [NR];
  int   gq [$];
  rsp_t exp_q [$];
  ln_ent_t ln_q [$];

  always #5 clk = ~clk;

  ln_row_scheduler_if #(.NUM_REQ(NR), .ROW_W(RW), .MAX_INFLIGHT(MI)) bus ();

  ln_row_scheduler #(.NUM_REQ(NR), .ROW_W(RW), .MAX_INFLIGHT(MI), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [RW-1:0] make_row(int id, int s);
    logic [RW-1:0] r;
    for (int w = 0; w < RW/32; w++) r[w*32 +: 32] = 32'(id*32'h0100_0000 + s*32'h100 + w);
    return r;
  endfunction

  // Stand-in for the normalizer: lane rotate plus constant, distinct per row.
  function automatic logic [RW-1:0] ln_model(logic [RW-1:0] x);
    return {x[RW-17:0], x[RW-1:RW-16]} ^ {(RW/16){16'h3C00}};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_iss(int n, int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (n_iss >= n) break;
    end
    if (k == budget) chk("timeout_issue", 32'(n_iss), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic wait_ret(int n, int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (n_ret >= n) break;
    end
    if (k == budget) chk("timeout_retire", 32'(n_ret), 32'(n));
    @(posedge clk); #1;
  endtask

  // Requester rows and LN datapath: fixed latency, held output until retired.
  initial begin
    logic r, iss, ret;
    logic [RW-1:0] a;
    logic [NR-1:0] rr;
    bus.ln_out_valid = 1'b0;
    bus.ln_norm_vec  = '0;
    for (int i = 0; i < NR; i++) bus.req_row[i] = make_row(i, 0);
    forever begin
      @(negedge clk);
      r   = rst;
      iss = bus.ln_x_valid & bus.ln_input_ready;
      ret = bus.ln_out_valid & bus.ln_downstream_ready;
      a   = bus.ln_a;
      rr  = bus.req_ready;
      @(posedge clk); #2;
      if (r) ln_q.delete();
      else begin
        if (ret && ln_q.size() > 0) void'(ln_q.pop_front());
        if (iss) begin
          ln_q.push_back('{row: a, t: cyc + LAT});
          for (int i = 0; i < NR; i++) if (rr[i]) sent[i]++;
        end
      end
      cyc++;
      bus.ln_out_valid = force_out || (ln_q.size() > 0 && cyc >= ln_q[0].t);
      bus.ln_norm_vec  = (ln_q.size() > 0) ? ln_model(ln_q[0].row) : '0;
      for (int i = 0; i < NR; i++) bus.req_row[i] = make_row(i, sent[i]);
    end
  end

  // Monitor: checks every issue against the directed grant order and every
  // retire against the expected owner and payload.
  initial begin
    int g;
    rsp_t e;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.ln_x_valid && bus.ln_input_ready) begin
          n_iss++;
          if (gq.size() == 0) chk("unexpected_issue", 32'(bus.req_ready), 32'(0));
          else begin
            g  = gq.pop_front();
            oh = '0; oh[g] = 1'b1;
            chk("grant", 32'(bus.req_ready), 32'(oh));
            exp_q.push_back('{id: g, row: ln_model(make_row(g, sent[g]))});
          end
        end
        if (bus.ln_out_valid && bus.ln_downstream_ready) begin
          n_ret++;
          if (exp_q.size() == 0) chk("unexpected_retire", 32'(bus.rsp_valid), 32'(0));
          else begin
            e  = exp_q.pop_front();
            oh = '0; oh[e.id] = 1'b1;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
            checks++;
            if (bus.rsp_row !== e.row) begin
              errors++;
              $display("FAIL rsp_row act=%h exp=%h", bus.rsp_row[63:0], e.row[63:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog n_iss=%0d n_ret=%0d", n_iss, n_ret);
    $fatal(1);
  end

  initial begin
    int fd;
    bus.req_valid = '0; bus.ln_input_ready = 1'b0; bus.rsp_ready = '0; bus.flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus.ln_input_ready = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("idle_x_valid", 32'(bus.ln_x_valid), 0);
      chk("idle_req_ready", 32'(bus.req_ready), 0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("idle_cnt", 32'(bus.inflight_cnt), 0);
      chk("idle_tag_err", 32'(bus.tag_err), 0);
    end
    @(posedge clk); #1;

    // 2: all requesting, round-robin order, in-order return
    for (int k = 0; k < 8; k++) gq.push_back(k % NR);
    bus.rsp_ready = 4'hF; bus.req_valid = 4'hF;
    wait_iss(8, 100);
    bus.req_valid = '0;
    wait_ret(8, 200);
    chk("t2_cnt_zero", 32'(bus.inflight_cnt), 0);

    // 3: credit limit with output stalled, then one issue per retire
    bus.rsp_ready = '0;
    for (int k = 0; k < 4; k++) gq.push_back(k);
    bus.req_valid = 4'hF;
    wait_iss(12, 100);
    repeat (14) @(posedge clk);
    @(negedge clk); #1;
    chk("t3_cnt_full", 32'(bus.inflight_cnt), 4);
    chk("t3_req_ready", 32'(bus.req_ready), 0);
    chk("t3_x_valid", 32'(bus.ln_x_valid), 0);
    chk("t3_head_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_ds_ready", 32'(bus.ln_downstream_ready), 0);
    chk("t3_issues", 32'(n_iss), 12);
    @(posedge clk); #1;
    gq.push_back(0); gq.push_back(1);
    bus.rsp_ready = 4'hF;
    @(negedge clk); #1;
    chk("t3_ds_ready_up", 32'(bus.ln_downstream_ready), 1);
    chk("t3_still_full", 32'(bus.ln_x_valid), 0);
    @(negedge clk); #1;
    chk("t3_cnt_after_retire", 32'(bus.inflight_cnt), 3);
    chk("t3_credit_freed", 32'(bus.ln_x_valid), 1);
    wait_iss(14, 50);
    bus.req_valid = '0;
    wait_ret(14, 100);

    // 4: simultaneous issue and retire at two in flight
    bus.rsp_ready = '0;
    gq.push_back(2); gq.push_back(3);
    bus.req_valid = 4'hF;
    wait_iss(16, 50);
    bus.req_valid = '0;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    chk("t4_cnt_two", 32'(bus.inflight_cnt), 2);
    @(posedge clk); #1;
    gq.push_back(0);
    bus.req_valid = 4'b0001; bus.rsp_ready = 4'hF;
    @(negedge clk); #1;
    chk("t4_both_x", 32'(bus.ln_x_valid), 1);
    chk("t4_both_ds", 32'(bus.ln_downstream_ready), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("t4_cnt_hold", 32'(bus.inflight_cnt), 2);
    wait_ret(17, 100);

    // 5: flush with three in flight and requests still pending
    bus.rsp_ready = '0;
    gq.push_back(1); gq.push_back(2); gq.push_back(3);
    bus.req_valid = 4'hF;
    wait_iss(20, 50);
    bus.ln_input_ready = 1'b0; bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.ln_input_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    chk("t5_no_grant", 32'(bus.req_ready), 0);
    chk("t5_cnt", 32'(bus.inflight_cnt), 3);
    chk("t5_no_done", 32'(bus.flush_done), 0);
    @(posedge clk); #1;
    bus.rsp_ready = 4'hF;
    fd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (bus.flush_done) begin
        fd++;
        chk("t5_done_cnt", 32'(bus.inflight_cnt), 0);
        chk("t5_done_retired", 32'(n_ret), 20);
      end
      @(posedge clk); #1;
      if (fd > 0) begin bus.flush_req = 1'b0; bus.req_valid = '0; end
    end
    chk("t5_done_pulses", 32'(fd), 1);

    // 6: return with empty tag FIFO, then reset mid-traffic
    force_out = 1'b1;
    @(negedge clk); #1;
    chk("t6_ds_ready", 32'(bus.ln_downstream_ready), 0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    force_out = 1'b0;
    @(negedge clk); #1;
    chk("t6_tag_err", 32'(bus.tag_err), 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("t6_tag_err_sticky", 32'(bus.tag_err), 1);
    @(posedge clk); #1;
    bus.rsp_ready = '0;
    gq.push_back(0); gq.push_back(1);
    bus.req_valid = 4'hF;
    wait_iss(22, 50);
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("t6_cnt_two", 32'(bus.inflight_cnt), 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); gq.delete();
    chk("t6_rst_cnt", 32'(bus.inflight_cnt), 0);
    chk("t6_rst_tag_err", 32'(bus.tag_err), 0);
    gq.push_back(0);
    bus.rsp_ready = 4'hF; bus.req_valid = 4'b1001;
    wait_iss(23, 50);
    bus.req_valid = '0;
    wait_ret(21, 100);
    chk("t6_final_cnt", 32'(bus.inflight_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
